// File: rtl/quota_stream_gen_if.sv
// Handshake bundle for quota_stream_gen: vector input side and bit-stream output side.
interface quota_stream_gen_if #(
  parameter int CHANNELS = 4,
  parameter int QUANT    = 8,
  parameter int QW       = 7
);
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*QUANT-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS-1:0]       out_bits;
  logic                      out_last;
  logic [CHANNELS*QW-1:0]    out_quota;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bits, out_last, out_quota
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bits, out_last, out_quota
  );
endinterface

// File: rtl/quota_stream_gen.sv
// Multi-channel quota-to-bitstream generator for the stochastic-computing datapath.
// Define QUOTA_SCRAMBLE_EN to bit-reverse the beat key (low-discrepancy streams).
module quota_stream_gen #(
  parameter int BITSTREAM = 64,
  parameter int QUANT     = 8,
  parameter int CHANNELS  = 4
) (
  input  logic             clk,
  input  logic             rst,
  quota_stream_gen_if.slave s
);
  localparam int LB = $clog2(BITSTREAM);
  localparam int S  = QUANT - LB;
  localparam int QW = LB + 1;

  generate
    if (BITSTREAM < 2 || (BITSTREAM & (BITSTREAM - 1)) != 0) begin : g_bad_bitstream
      $error("quota_stream_gen: BITSTREAM must be a power of 2 and >= 2");
    end
    if (QUANT < LB) begin : g_bad_quant
      $error("quota_stream_gen: QUANT must be >= $clog2(BITSTREAM)");
    end
  endgenerate

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  localparam logic [LB-1:0] CNT_MAX = LB'(BITSTREAM - 1);
  // Rounding constant collapses to zero when no bits are dropped (S == 0).
  localparam logic [QUANT:0] HALF = (S > 0) ? (QUANT+1)'(1 << ((S > 0) ? S - 1 : 0)) : '0;

  logic [0:0]               state_q, state_d;
  logic [LB-1:0]            cnt_q, cnt_d;
  logic [CHANNELS*QW-1:0]   quota_q, quota_d;
  logic [CHANNELS*QW-1:0]   quota_new;
  logic [LB-1:0]            key;
  logic                     streaming;
  logic                     last_beat;
  logic                     accept;
  logic [CHANNELS-1:0]      bits;

  assign streaming = (state_q == ST_STREAM);
  assign last_beat = streaming && (cnt_q == CNT_MAX);
  assign s.in_ready = !streaming || (s.out_ready && last_beat);
  assign accept    = s.in_valid && s.in_ready;

  // Bias to unsigned by flipping the sign bit, then round half-up into LB+1 bits.
  always_comb begin
    logic [QUANT:0] u;
    logic [QUANT:0] r;
    quota_new = '0;
    u = '0;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      u = {1'b0, ~s.in_data[c*QUANT + QUANT - 1], s.in_data[c*QUANT +: QUANT-1]};
      r = (u + HALF) >> S;
      quota_new[c*QW +: QW] = r[QW-1:0];
    end
  end

`ifdef QUOTA_SCRAMBLE_EN
  always_comb begin
    key = '0;
    for (int i = 0; i < LB; i++) begin
      key[i] = cnt_q[LB-1-i];
    end
  end
`else
  assign key = cnt_q;
`endif

  always_comb begin
    bits = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      bits[c] = streaming && ({1'b0, key} < quota_q[c*QW +: QW]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quota_d = quota_q;
    if (!streaming) begin
      if (accept) begin
        quota_d = quota_new;
        cnt_d   = '0;
        state_d = ST_STREAM;
      end
    end else if (s.out_ready) begin
      if (last_beat) begin
        cnt_d = '0;
        if (accept) begin
          quota_d = quota_new;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        cnt_d = cnt_q + LB'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      quota_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quota_q <= quota_d;
    end
  end

  assign s.out_valid = streaming;
  assign s.out_bits  = bits;
  assign s.out_last  = last_beat;
  assign s.out_quota = quota_q;
endmodule

// File: tb/tb_quota_stream_gen.sv
// Directed self-checking bench for quota_stream_gen (64-beat and 256-beat builds).
// Expected bit patterns follow QUOTA_SCRAMBLE_EN when it is defined.
module tb_quota_stream_gen;
  localparam int C   = 4;
  localparam int Q   = 8;
  localparam int B   = 64;
  localparam int QW  = 7;
  localparam int B2  = 256;
  localparam int QW2 = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quota_stream_gen_if #(.CHANNELS(C), .QUANT(Q), .QW(QW))  m  ();
  quota_stream_gen_if #(.CHANNELS(C), .QUANT(Q), .QW(QW2)) m2 ();

  quota_stream_gen #(.BITSTREAM(B), .QUANT(Q), .CHANNELS(C)) dut (
    .clk (clk),
    .rst (rst),
    .s   (m.slave)
  );

  quota_stream_gen #(.BITSTREAM(B2), .QUANT(Q), .CHANNELS(C)) dut2 (
    .clk (clk),
    .rst (rst),
    .s   (m2.slave)
  );

  int passCount  = 0;
  int checkCount = 0;
  int qExp [C];
  int pop  [C];
  int validErr, lastErr, bitErr, quotaErr, readyErr, stallErr;

  localparam logic [31:0] VEC_A = {8'h02, 8'h00, 8'h7F, 8'h80};
  localparam logic [31:0] VEC_B = {8'hC0, 8'h40, 8'hFF, 8'h01};

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
    m.in_valid  = v;
    m.in_data   = d;
    m.out_ready = r;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int keyOf(input int k, input int lb);
`ifdef QUOTA_SCRAMBLE_EN
    int r = 0;
    for (int i = 0; i < lb; i++) r = r | (((k >> i) & 1) << (lb - 1 - i));
    return r;
`else
    return k + 0 * lb;
`endif
  endfunction

  function automatic logic [C*QW-1:0] packQ();
    logic [C*QW-1:0] p = '0;
    for (int c = 0; c < C; c++) p[c*QW +: QW] = QW'(qExp[c]);
    return p;
  endfunction

  function automatic logic [C*QW2-1:0] packQ2();
    logic [C*QW2-1:0] p = '0;
    for (int c = 0; c < C; c++) p[c*QW2 +: QW2] = QW2'(qExp[c]);
    return p;
  endfunction

  task automatic clearStats();
    for (int c = 0; c < C; c++) pop[c] = 0;
    validErr = 0; lastErr = 0; bitErr = 0; quotaErr = 0; readyErr = 0; stallErr = 0;
  endtask

  // Consumes one full stream with out_ready held high, starting on a presented beat 0.
  task automatic collectBeats();
    logic [C*QW-1:0] qp;
    qp = packQ();
    clearStats();
    for (int k = 0; k < B; k++) begin
      @(negedge clk);
      if (m.out_valid !== 1'b1) validErr++;
      if (m.out_last !== (k == B - 1)) lastErr++;
      if (m.in_ready !== (k == B - 1)) readyErr++;
      if (m.out_quota !== qp) quotaErr++;
      for (int c = 0; c < C; c++) begin
        if (m.out_bits[c] === 1'b1) pop[c]++;
        if (m.out_bits[c] !== (keyOf(k, 6) < qExp[c])) bitErr++;
      end
      nextCycle();
    end
  endtask

  task automatic checkStream(input string tag);
    checkOutput({tag, "_valid_gaps"}, validErr, 0);
    checkOutput({tag, "_last_pos"},   lastErr,  0);
    checkOutput({tag, "_ready_pos"},  readyErr, 0);
    checkOutput({tag, "_quota_hold"}, quotaErr, 0);
    checkOutput({tag, "_bit_pattern"}, bitErr,  0);
    for (int c = 0; c < C; c++) checkOutput($sformatf("%s_pop%0d", tag, c), pop[c], qExp[c]);
  endtask

  initial begin
    logic [C-1:0] heldBits;
    logic         heldLast;
    logic         prevStall;
    int           consumed;
    int           cycles;

    applyStimulus(1'b0, '0, 1'b0);
    m2.in_valid = 1'b0; m2.in_data = '0; m2.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", m.out_valid, 0);
    checkOutput("reset_out_bits",  m.out_bits,  0);
    checkOutput("reset_out_last",  m.out_last,  0);
    checkOutput("reset_out_quota", m.out_quota, 0);
    checkOutput("reset_in_ready",  m.in_ready,  1);
    nextCycle();
    rst = 1'b0;

    $display("[TB] test 1/2: single stream, out_ready high");
    qExp = '{0, 64, 32, 33};
    applyStimulus(1'b1, VEC_A, 1'b1);
    @(negedge clk);
    checkOutput("t1_accept_ready", m.in_ready, 1);
    checkOutput("t1_accept_valid", m.out_valid, 0);
    nextCycle();
    applyStimulus(1'b0, VEC_A, 1'b1);
    checkOutput("t1_quota", m.out_quota, packQ());
    collectBeats();
    checkStream("t1");
    @(negedge clk);
    checkOutput("t1_idle_after", m.out_valid, 0);
    checkOutput("t1_idle_bits",  m.out_bits,  0);
    nextCycle();

    $display("[TB] test 3: random backpressure");
    applyStimulus(1'b1, VEC_A, 1'b1);
    nextCycle();
    applyStimulus(1'b0, VEC_A, 1'b0);
    clearStats();
    consumed = 0; cycles = 0; prevStall = 1'b0; heldBits = '0; heldLast = 1'b0;
    while (consumed < B && cycles < 2000) begin
      m.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prevStall && (m.out_bits !== heldBits || m.out_last !== heldLast)) stallErr++;
      if (m.out_valid !== 1'b1) validErr++;
      if (m.out_quota !== packQ()) quotaErr++;
      if (m.out_last !== (consumed == B - 1)) lastErr++;
      for (int c = 0; c < C; c++)
        if (m.out_bits[c] !== (keyOf(consumed, 6) < qExp[c])) bitErr++;
      prevStall = m.out_valid && !m.out_ready;
      heldBits  = m.out_bits;
      heldLast  = m.out_last;
      if (m.out_valid && m.out_ready) begin
        for (int c = 0; c < C; c++) if (m.out_bits[c] === 1'b1) pop[c]++;
        consumed++;
      end
      cycles++;
      nextCycle();
    end
    m.out_ready = 1'b1;
    checkOutput("t3_consumed", consumed, B);
    checkOutput("t3_stall_hold", stallErr, 0);
    checkOutput("t3_valid", validErr, 0);
    checkOutput("t3_last", lastErr, 0);
    checkOutput("t3_quota", quotaErr, 0);
    checkOutput("t3_bits", bitErr, 0);
    for (int c = 0; c < C; c++) checkOutput($sformatf("t3_pop%0d", c), pop[c], qExp[c]);
    @(negedge clk);
    checkOutput("t3_idle_after", m.out_valid, 0);
    nextCycle();

    $display("[TB] test 4: back-to-back vectors with in_valid held");
    applyStimulus(1'b1, VEC_A, 1'b1);
    nextCycle();
    applyStimulus(1'b1, VEC_B, 1'b1);
    collectBeats();
    checkStream("t4a");
    applyStimulus(1'b0, VEC_B, 1'b1);
    qExp = '{32, 32, 48, 16};
    collectBeats();
    checkStream("t4b");
    @(negedge clk);
    checkOutput("t4_idle_after", m.out_valid, 0);
    nextCycle();

    $display("[TB] test 5: reset mid-stream");
    qExp = '{0, 64, 32, 33};
    applyStimulus(1'b1, VEC_A, 1'b1);
    nextCycle();
    applyStimulus(1'b0, VEC_A, 1'b1);
    repeat (20) nextCycle();
    @(negedge clk);
    checkOutput("t5_beat20_valid", m.out_valid, 1);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_rst_valid", m.out_valid, 0);
    checkOutput("t5_rst_ready", m.in_ready,  1);
    checkOutput("t5_rst_quota", m.out_quota, 0);
    checkOutput("t5_rst_bits",  m.out_bits,  0);
    nextCycle();
    applyStimulus(1'b1, VEC_A, 1'b1);
    nextCycle();
    applyStimulus(1'b0, VEC_A, 1'b1);
    collectBeats();
    checkStream("t5");

    $display("[TB] test 6: 256-beat build, S=0");
    qExp = '{127, 255, 0, 128};
    m2.in_valid = 1'b1; m2.in_data = {8'h00, 8'h80, 8'h7F, 8'hFF}; m2.out_ready = 1'b1;
    nextCycle();
    m2.in_valid = 1'b0;
    checkOutput("t6_quota", m2.out_quota, packQ2());
    clearStats();
    for (int k = 0; k < B2; k++) begin
      @(negedge clk);
      if (m2.out_valid !== 1'b1) validErr++;
      if (m2.out_last !== (k == B2 - 1)) lastErr++;
      for (int c = 0; c < C; c++) begin
        if (m2.out_bits[c] === 1'b1) pop[c]++;
        if (m2.out_bits[c] !== (keyOf(k, 8) < qExp[c])) bitErr++;
      end
      nextCycle();
    end
    checkOutput("t6_valid", validErr, 0);
    checkOutput("t6_last",  lastErr,  0);
    checkOutput("t6_bits",  bitErr,   0);
    for (int c = 0; c < C; c++) checkOutput($sformatf("t6_pop%0d", c), pop[c], qExp[c]);
    @(negedge clk);
    checkOutput("t6_idle_after", m2.out_valid, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
